// File: rtl/dac_spi_master_if.sv
// Write-FIFO handshake and readback bus between slow-control logic and dac_spi_master.
// master = slow-control side, slave = the SPI master block.
interface dac_spi_master_if #(
  parameter int unsigned CMD_W      = 4,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

  logic [CMD_W-1:0]  wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_upd;
  logic              wr_valid;
  logic              wr_ready;
  logic [LvlW-1:0]   fifo_level;
  logic              busy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output wr_cmd, wr_addr, wr_data, wr_upd, wr_valid,
    input  wr_ready, fifo_level, busy, rd_data, rd_valid
  );

  modport slave (
    input  wr_cmd, wr_addr, wr_data, wr_upd, wr_valid,
    output wr_ready, fifo_level, busy, rd_data, rd_valid
  );
endinterface

// File: rtl/dac_spi_master.sv
// SPI master for DAC/ADC configuration: FIFO-buffered {cmd, addr, data} frames shifted MSB first,
// SDO captured for readback, optional LDAC pulse after each frame.
module dac_spi_master #(
  parameter int unsigned CMD_W      = 4,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned HALF_DIV   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SYNC_GAP   = 2,
  parameter int unsigned LDAC_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  dac_spi_master_if.slave bus,
  input  logic            spi_sdo,
  output logic            spi_sclk,
  output logic            spi_sync,
  output logic            spi_data,
  output logic            spi_enable,
  output logic            spi_ldac_n
);
  localparam int unsigned N    = CMD_W + ADDR_W + DATA_W;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BitW = $clog2(N);
  localparam int unsigned MaxA = (HALF_DIV > LDAC_W) ? HALF_DIV : LDAC_W;
  localparam int unsigned MaxT = (MaxA > SYNC_GAP) ? MaxA : SYNC_GAP;
  localparam int unsigned CntW = (MaxT > 1) ? $clog2(MaxT) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StLdac, StGap} state_e;

  // Write FIFO; entry = {upd, cmd, addr, data}
  logic [N:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [LvlW-1:0] level_q;
  logic            push, pop;
  logic [N:0]      head;

  assign bus.wr_ready   = (level_q < LvlW'(FIFO_DEPTH));
  assign bus.fifo_level = level_q;
  assign push           = bus.wr_valid && bus.wr_ready;
  assign head           = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {bus.wr_upd, bus.wr_cmd, bus.wr_addr, bus.wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  // Frame sequencer
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              phase_q, phase_d;  // 0: SCLK high (A), 1: SCLK low (B)
  logic [N-1:0]      shreg_q, shreg_d;
  logic              upd_q, upd_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              load;

  assign pop          = load;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state_q != StIdle) || (level_q != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    shreg_d    = shreg_q;
    upd_d      = upd_q;
    cap_d      = cap_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    load       = 1'b0;
    case (state_q)
      StIdle: load = (level_q != '0);
      StShift: begin
        if (cnt_q == CntW'(HALF_DIV - 1)) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Last clk of phase B: the device has had a full half-period to drive SDO
            cap_d = {cap_q[DATA_W-2:0], spi_sdo};
            if (bit_q == BitW'(N - 1)) begin
              rd_data_d  = cap_d;
              rd_valid_d = 1'b1;
              state_d    = upd_q ? StLdac : StGap;
            end else begin
              bit_d   = bit_q + BitW'(1);
              phase_d = 1'b0;
              shreg_d = {shreg_q[N-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLdac: begin
        if (cnt_q == CntW'(LDAC_W - 1)) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(SYNC_GAP - 1)) begin
          cnt_d = '0;
          if (level_q != '0) load = 1'b1;
          else               state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      state_d = StShift;
      shreg_d = head[N-1:0];
      upd_d   = head[N];
      cnt_d   = '0;
      bit_d   = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      shreg_q    <= '0;
      upd_q      <= 1'b0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      shreg_q    <= shreg_d;
      upd_q      <= upd_d;
      cap_q      <= cap_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Pins are flopped from next-state so they line up with the sequencer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_sclk   <= 1'b1;
      spi_sync   <= 1'b1;
      spi_data   <= 1'b0;
      spi_enable <= 1'b0;
      spi_ldac_n <= 1'b1;
    end else begin
      spi_sync   <= (state_d != StShift);
      spi_enable <= (state_d == StShift);
      spi_sclk   <= !((state_d == StShift) && phase_d);
      spi_data   <= (state_d == StShift) && shreg_d[N-1];
      spi_ldac_n <= (state_d != StLdac);
    end
  end
endmodule
